// File: rtl/mem_responder.sv
// Word-addressed memory behind a four-phase read/write handshake,
// with a programmable number of wait states before each access.
module mem_responder #(
    parameter int WORD_LENGTH = 8,
    parameter int ADDR_LENGTH = 13,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_LENGTH-1:0] address,
    input  logic [WORD_LENGTH-1:0] write_data,
    input  logic                   mem_read,
    input  logic                   mem_write,
    output logic [WORD_LENGTH-1:0] command,
    output logic                   ready,
    output logic                   error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                   state, state_nx;
    logic [3:0]               cnt, cnt_nx;
    logic [ADDR_LENGTH-1:0]   addr_q;
    logic [WORD_LENGTH-1:0]   data_q;
    logic                     wr_q;
    logic                     accept;
    logic                     access;
    logic                     err_nx;

    logic [WORD_LENGTH-1:0] mem [0:(1<<ADDR_LENGTH)-1];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        access   = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_read ^ mem_write) begin
                    accept   = 1'b1;
                    cnt_nx   = WAIT_INIT;
                    state_nx = BUSY;
                end else if (mem_read && mem_write) begin
                    err_nx = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    access   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                // Wait for the initiator to drop both requests.
                if (!mem_read && !mem_write) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready   <= 1'b0;
            error   <= 1'b0;
            command <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ready <= (state_nx == DONE);
            error <= err_nx;
            if (accept) begin
                addr_q <= address;
                data_q <= write_data;
                wr_q   <= mem_write;
            end
            if (access && !wr_q) begin
                command <= mem[addr_q];
            end
        end
    end

    // Array is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (access && wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and random checks of mem_responder against a simple
// array/latency model, with 2 and 0 wait states.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] addr [2];
    logic [7:0]  wd   [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [7:0]  cmd  [2];
    logic        rdy  [2];
    logic        err  [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mm [2][8192];
    logic [7:0]  exp_cmd [2];
    logic [12:0] wa0 [$];
    logic [12:0] wa1 [$];
    int          waits [2] = '{2, 0};

    always #5 clk = ~clk;

    mem_responder #(.WORD_LENGTH(8), .ADDR_LENGTH(13), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .address(addr[0]), .write_data(wd[0]),
        .mem_read(rd[0]), .mem_write(wr[0]),
        .command(cmd[0]), .ready(rdy[0]), .error(err[0])
    );

    mem_responder #(.WORD_LENGTH(8), .ADDR_LENGTH(13), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .address(addr[1]), .write_data(wd[1]),
        .mem_read(rd[1]), .mem_write(wr[1]),
        .command(cmd[1]), .ready(rdy[1]), .error(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int s, input bit is_wr, input logic [12:0] a,
                       input logic [7:0] d, input bit drop, input int hold);
        int lat;
        lat = waits[s] + 2;
        addr[s] = a;
        wd[s]   = d;
        rd[s]   = !is_wr;
        wr[s]   = is_wr;
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k == 1) begin
                // Latched values must win over anything changed after accept.
                wd[s]   = ~d;
                addr[s] = a ^ 13'h1;
                if (drop) begin
                    rd[s] = 1'b0;
                    wr[s] = 1'b0;
                end
            end
            check($sformatf("ready_lat s%0d k%0d", s, k), 32'(rdy[s]),
                  32'(k == lat));
            check($sformatf("error_txn s%0d k%0d", s, k), 32'(err[s]), 0);
        end
        if (is_wr) begin
            mm[s][a] = d;
            if (s == 0) wa0.push_back(a); else wa1.push_back(a);
        end else begin
            exp_cmd[s] = mm[s][a];
        end
        check($sformatf("command s%0d a%0h", s, a), 32'(cmd[s]),
              32'(exp_cmd[s]));
        if (!drop) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                check($sformatf("ready_hold s%0d h%0d", s, h), 32'(rdy[s]), 1);
            end
            rd[s] = 1'b0;
            wr[s] = 1'b0;
        end
        tick();
        check($sformatf("ready_end s%0d", s), 32'(rdy[s]), 0);
        check($sformatf("cmd_end s%0d", s), 32'(cmd[s]), 32'(exp_cmd[s]));
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            addr[s] = '0; wd[s] = '0; rd[s] = 1'b0; wr[s] = 1'b0;
            exp_cmd[s] = 8'h00;
        end
        rst = 1'b0;
        #3;
        for (int s = 0; s < 2; s++) begin
            check("reset_ready", 32'(rdy[s]), 0);
            check("reset_error", 32'(err[s]), 0);
            check("reset_cmd", 32'(cmd[s]), 0);
        end
        tick();
        tick();
        #2 rst = 1'b1;

        // Write then read with two wait states.
        txn(0, 1'b1, 13'h1F00, 8'hA5, 1'b0, 0);
        txn(0, 1'b0, 13'h1F00, 8'h00, 1'b0, 0);

        // Held read, then a held write whose data changes mid-hold.
        txn(0, 1'b0, 13'h1F00, 8'h00, 1'b0, 17);
        txn(0, 1'b1, 13'h0123, 8'h77, 1'b0, 5);
        txn(0, 1'b0, 13'h0123, 8'h00, 1'b0, 0);

        // Illegal request for three cycles.
        addr[0] = 13'h0123; wd[0] = 8'hEE; rd[0] = 1'b1; wr[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("illegal_error k%0d", k), 32'(err[0]), 1);
            check($sformatf("illegal_ready k%0d", k), 32'(rdy[0]), 0);
            check($sformatf("illegal_cmd k%0d", k), 32'(cmd[0]),
                  32'(exp_cmd[0]));
        end
        rd[0] = 1'b0; wr[0] = 1'b0;
        tick();
        check("illegal_clear", 32'(err[0]), 0);
        txn(0, 1'b0, 13'h0123, 8'h00, 1'b0, 0);

        // Reset during the wait states of a write.
        txn(0, 1'b1, 13'h0005, 8'h11, 1'b0, 0);
        txn(0, 1'b0, 13'h0005, 8'h00, 1'b0, 0);
        addr[0] = 13'h0005; wd[0] = 8'h3C; wr[0] = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ready", 32'(rdy[0]), 0);
        check("rst_mid_error", 32'(err[0]), 0);
        check("rst_mid_cmd", 32'(cmd[0]), 0);
        wr[0] = 1'b0;
        tick();
        check("rst_hold_ready", 32'(rdy[0]), 0);
        check("rst_hold_cmd", 32'(cmd[0]), 0);
        exp_cmd[0] = 8'h00;
        exp_cmd[1] = 8'h00;
        #2 rst = 1'b1;
        txn(0, 1'b0, 13'h0005, 8'h00, 1'b0, 0);

        // Zero wait states at both ends of the address range.
        txn(1, 1'b1, 13'h0000, 8'h5A, 1'b1, 0);
        txn(1, 1'b1, 13'h1FFF, 8'hC3, 1'b1, 0);
        txn(1, 1'b0, 13'h0000, 8'h00, 1'b1, 0);
        txn(1, 1'b0, 13'h1FFF, 8'h00, 1'b1, 0);

        // Random traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            int          s;
            bit          is_wr;
            logic [12:0] a;
            s     = int'($urandom_range(0, 1));
            is_wr = bit'($urandom_range(0, 1));
            if (is_wr) begin
                a = 13'($urandom);
            end else if (s == 0) begin
                a = wa0[$urandom_range(0, wa0.size() - 1)];
            end else begin
                a = wa1[$urandom_range(0, wa1.size() - 1)];
            end
            txn(s, is_wr, a, 8'($urandom), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WORD_LENGTH, default 8: data word width in bits.
REQ-002 Parameter ADDR_LENGTH, default 13: address width; the array SHALL hold 2^ADDR_LENGTH words.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15: wait states inserted before each access.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 address  input  ADDR_LENGTH  word address of the request.
REQ-007 write_data  input  WORD_LENGTH  data to store on a write.
REQ-008 mem_read  input  1  read request, level, held by the initiator.
REQ-009 mem_write  input  1  write request, level, held by the initiator.
REQ-010 command  output  WORD_LENGTH  registered read data.
REQ-011 ready  output  1  registered completion acknowledge.
REQ-012 error  output  1  registered illegal-request flag.

Function
REQ-013 The block SHALL implement a 4-phase responder FSM with states IDLE, BUSY and DONE.
REQ-014 In IDLE with exactly one of mem_read or mem_write high, the block SHALL latch address, write_data and the operation, load the wait counter with WAIT_CYCLES, and go to BUSY.
REQ-015 In IDLE with both mem_read and mem_write high, the block SHALL stay in IDLE, set error=1 for every such cycle, and perform no access.
REQ-016 error SHALL be 0 in any cycle that does not meet REQ-015.
REQ-017 In BUSY with counter ≠ 0, the block SHALL decrement the counter.
REQ-018 In BUSY with counter = 0, the block SHALL perform the latched access and go to DONE.
REQ-019 A read SHALL load command with array[latched address].
REQ-020 A write SHALL store the latched write_data at the latched address and SHALL leave command unchanged.
REQ-021 Request latency: ready SHALL first be high WAIT_CYCLES+2 rising edges after the accepting IDLE edge, counting that edge. With WAIT_CYCLES=0, ready is high after 2 edges.
REQ-022 ready SHALL be 1 exactly while the FSM is in DONE.
REQ-023 DONE SHALL go to IDLE on the first edge at which mem_read and mem_write are both 0. A request held high SHALL therefore never cause a second access.
REQ-024 Input changes during BUSY or DONE SHALL be ignored; only the latched values are used.
REQ-025 A request dropped during BUSY SHALL NOT abort the access. DONE SHALL then last exactly one cycle.
REQ-026 command SHALL hold its value until the next completed read.
REQ-027 A read of a just-written address SHALL return the new data.
REQ-028 The wait counter SHALL be 4 bits wide and SHALL never wrap below 0.

Reset
REQ-029 While rst=0, the block SHALL hold state=IDLE, counter=0, ready=0, error=0 and command=0, asynchronously.
REQ-030 Reset asserted during BUSY SHALL abort the access; no array write occurs.
REQ-031 Array contents SHALL NOT be altered by rst.
REQ-032 After rst returns to 1, the first request SHALL be sampled on the next rising edge.

Verification
REQ-033 Write then read: write 0xA5 to 0x1F00, release, then read 0x1F00. Required: ready high on the 4th edge after each accept (WAIT_CYCLES=2), and command=0xA5.
REQ-034 Held request: hold mem_read high for 20 cycles at one address. Required: ready stays high from the 4th edge until release, and exactly one access occurs.
REQ-035 Illegal request: raise mem_read and mem_write together for 3 cycles. Required: error=1 for those 3 cycles, ready=0, and command and array unchanged.
REQ-036 Reset mid-access: start a write of 0x3C to 0x0005, pulse rst low during BUSY, then read 0x0005. Required: the prior contents are returned, and ready/error/command are 0 during reset.
REQ-037 Boundaries with WAIT_CYCLES=0: write and read at addresses 0x0000 and 0x1FFF, dropping the request during BUSY. Required: ready on the 2nd edge, one-cycle DONE, and correct data.
